// File: rtl/io_sample_fifo_pkg.sv
// Shared definitions for the pad sampler: register offsets, CTRL/STATUS bit
// positions, the 24-bit FIFO entry layout and a couple of small helpers.
package io_sample_fifo_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_DIV    = 8'h04;
    localparam logic [7:0] REG_STATUS = 8'h08;
    localparam logic [7:0] REG_DATA   = 8'h0C;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_LSB_LO = 8;
    localparam int CTRL_LSB_HI = 13;
    localparam int CTRL_FLUSH  = 31;

    localparam int STATUS_EMPTY = 8;
    localparam int STATUS_FULL  = 9;
    localparam int STATUS_OVF   = 10;

    localparam int SAMPLE_W = 8;
    localparam int TS_W     = 16;
    localparam int ENTRY_W  = TS_W + SAMPLE_W;
    localparam int IO_W     = 38;

    // Highest slice origin that still keeps sync[lsb+7] inside the 38 pads.
    localparam logic [5:0] LSB_MAX = 6'd30;

    typedef struct packed {
        logic [TS_W-1:0]     ts;
        logic [SAMPLE_W-1:0] sample;
    } entry_t;

    typedef struct packed {
        logic       irq_en;
        logic       mode;
        logic       en;
        logic [5:0] lsb;
    } ctrl_t;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_DIV,
        SEL_STATUS,
        SEL_DATA,
        SEL_NONE
    } reg_sel_t;

    function automatic reg_sel_t decode_reg(input logic [7:0] offset);
        case (offset)
            REG_CTRL:   return SEL_CTRL;
            REG_DIV:    return SEL_DIV;
            REG_STATUS: return SEL_STATUS;
            REG_DATA:   return SEL_DATA;
            default:    return SEL_NONE;
        endcase
    endfunction

    function automatic logic [5:0] clamp_lsb(input logic [5:0] value);
        return (value > LSB_MAX) ? LSB_MAX : value;
    endfunction

    function automatic logic [31:0] pack_ctrl(input ctrl_t c);
        logic [31:0] word;
        word                          = '0;
        word[CTRL_EN]                 = c.en;
        word[CTRL_MODE]               = c.mode;
        word[CTRL_IRQ_EN]             = c.irq_en;
        word[CTRL_LSB_HI:CTRL_LSB_LO] = c.lsb;
        return word;
    endfunction

endpackage

// File: rtl/io_sample_fifo_fifo.sv
// Single-clock FIFO with flush, sticky-free overflow strobe and occupancy count.
// Pointers carry one extra bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH      = 24,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      head_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_reg [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_reg;
    logic [DEPTH_LOG2:0] rd_ptr_reg;
    logic                do_push;
    logic                do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                   (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop & ~flush;

    assign head_data = mem_reg[rd_ptr_reg[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_reg[wr_ptr_reg[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/io_sample_fifo.sv
// Wishbone-mapped pad sampler: synchronises io_in, captures an 8-bit slice
// periodically or on change with a timestamp, and queues it for firmware.
module io_sample_fifo
    import io_sample_fifo_pkg::*;
#(
    parameter logic [31:0] address_base = 32'h30000500,
    parameter int          depth_log2   = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [IO_W-1:0] io_in,
    output logic            sample_irq
);

    logic [IO_W-1:0]     sync1_reg;
    logic [IO_W-1:0]     sync2_reg;
    logic [TS_W-1:0]     ts_reg;
    logic [15:0]         div_reg;
    logic [15:0]         div_cnt_reg;
    ctrl_t               ctrl_reg;
    ctrl_t               ctrl_next;
    logic [SAMPLE_W-1:0] last_reg;
    logic                overflow_reg;
    logic                ack_reg;
    logic [31:0]         dat_reg;
    logic [31:0]         dat_next;
    logic                irq_reg;

    logic                in_window;
    reg_sel_t            reg_sel;
    logic                req;
    logic                wr_ok;
    logic                ctrl_wr;
    logic                div_wr;
    logic                status_wr;
    logic                fifo_flush;
    logic                ovf_clr;
    logic                fifo_pop;
    logic                en_rise;

    logic [63:0]         sync_pad;
    logic [SAMPLE_W-1:0] slice_cur;
    logic [SAMPLE_W-1:0] slice_new;
    logic [5:0]          lsb_new;
    logic [15:0]         div_eff;
    logic                div_hit;
    logic                push_req;
    entry_t              push_entry;

    logic [ENTRY_W-1:0]  head_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic [depth_log2:0] fifo_count;
    logic                fifo_overflow;
    logic [31:0]         status_word;
    logic [31:0]         rdata;
    logic                unused_dat;

    assign unused_dat = ^wbs_dat_i[30:16];

    // ---------------- Wishbone decode ----------------
    assign in_window = (wbs_adr_i[31:8] == address_base[31:8]);
    assign reg_sel   = decode_reg(wbs_adr_i[7:0]);
    assign req       = wbs_cyc_i & wbs_stb_i & in_window & ~ack_reg;
    assign wr_ok     = req & wbs_we_i & (wbs_sel_i == 4'hF);
    assign ctrl_wr   = wr_ok & (reg_sel == SEL_CTRL);
    assign div_wr    = wr_ok & (reg_sel == SEL_DIV);
    assign status_wr = wr_ok & (reg_sel == SEL_STATUS);
    assign fifo_flush = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
    assign ovf_clr    = status_wr & wbs_dat_i[STATUS_OVF];
    assign fifo_pop   = req & ~wbs_we_i & (reg_sel == SEL_DATA);

    always_comb begin
        ctrl_next = ctrl_reg;
        if (ctrl_wr) begin
            ctrl_next.en     = wbs_dat_i[CTRL_EN];
            ctrl_next.mode   = wbs_dat_i[CTRL_MODE];
            ctrl_next.irq_en = wbs_dat_i[CTRL_IRQ_EN];
            ctrl_next.lsb    = clamp_lsb(wbs_dat_i[CTRL_LSB_HI:CTRL_LSB_LO]);
        end
    end

    assign en_rise = ctrl_next.en & ~ctrl_reg.en;
    assign lsb_new = ctrl_next.lsb;

    // ---------------- Slice selection ----------------
    // The enabling write may move lsb, so 'last' is seeded from the new origin.
    assign sync_pad = {{(64-IO_W){1'b0}}, sync2_reg};

    generate
        for (genvar gi = 0; gi < SAMPLE_W; gi++) begin : g_slice
            assign slice_cur[gi] = sync_pad[ctrl_reg.lsb + 6'(gi)];
            assign slice_new[gi] = sync_pad[lsb_new + 6'(gi)];
        end
    endgenerate

    // ---------------- Capture trigger ----------------
    assign div_eff  = (div_reg == 16'd0) ? 16'd1 : div_reg;
    assign div_hit  = (div_cnt_reg >= div_eff - 16'd1);
    assign push_req = ctrl_reg.en &
                      (ctrl_reg.mode ? (slice_cur != last_reg) : div_hit);

    assign push_entry.ts     = ts_reg;
    assign push_entry.sample = slice_cur;

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (depth_log2)
    ) u_fifo (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (fifo_overflow)
    );

    // ---------------- Read mux ----------------
    always_comb begin
        status_word               = '0;
        status_word[4:0]          = 5'(fifo_count);
        status_word[STATUS_EMPTY] = fifo_empty;
        status_word[STATUS_FULL]  = fifo_full;
        status_word[STATUS_OVF]   = overflow_reg;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            SEL_CTRL:   rdata = pack_ctrl(ctrl_reg);
            SEL_DIV:    rdata = {16'd0, div_reg};
            SEL_STATUS: rdata = status_word;
            SEL_DATA:   rdata = fifo_empty ? 32'd0 : {8'd0, head_entry};
            default:    rdata = '0;
        endcase
    end

    assign dat_next = (req && !wbs_we_i) ? rdata : 32'd0;

    // ---------------- State ----------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            ts_reg       <= '0;
            ctrl_reg     <= '0;
            div_reg      <= '0;
            div_cnt_reg  <= '0;
            last_reg     <= '0;
            overflow_reg <= 1'b0;
            ack_reg      <= 1'b0;
            dat_reg      <= '0;
            irq_reg      <= 1'b0;
        end else begin
            sync1_reg <= io_in;
            sync2_reg <= sync1_reg;
            ts_reg    <= ts_reg + 16'd1;
            ctrl_reg  <= ctrl_next;

            if (div_wr) div_reg <= wbs_dat_i[15:0];

            if (en_rise) begin
                div_cnt_reg <= '0;
            end else if (ctrl_reg.en) begin
                div_cnt_reg <= div_hit ? 16'd0 : div_cnt_reg + 16'd1;
            end

            if (en_rise) begin
                last_reg <= slice_new;
            end else if (push_req) begin
                last_reg <= slice_cur;
            end

            // A new overflow in the clearing cycle keeps the flag set.
            if (fifo_overflow) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end

            ack_reg <= req;
            dat_reg <= dat_next;
            irq_reg <= ctrl_reg.irq_en & ~fifo_empty;
        end
    end

    assign wbs_ack_o  = ack_reg;
    assign wbs_dat_o  = dat_reg;
    assign sample_irq = irq_reg;

endmodule

// File: tb/tb_io_sample_fifo.sv
// Scenario bench for io_sample_fifo: expected FIFO entries are queued as the
// pins are driven and popped when firmware-style DATA reads return them.
module tb_io_sample_fifo;
    import io_sample_fifo_pkg::*;

    localparam logic [31:0] BASE     = 32'h30000500;
    localparam logic [31:0] A_CTRL   = BASE + 32'(REG_CTRL);
    localparam logic [31:0] A_DIV    = BASE + 32'(REG_DIV);
    localparam logic [31:0] A_STATUS = BASE + 32'(REG_STATUS);
    localparam logic [31:0] A_DATA   = BASE + 32'(REG_DATA);

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic [37:0] io;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] sb_q[$];
    logic [15:0] tb_ts;

    always #5 clk = ~clk;

    // Reference timestamp: zero in reset, +1 every clock afterwards.
    always @(posedge clk) tb_ts <= rst ? 16'd0 : tb_ts + 16'd1;

    io_sample_fifo #(.address_base(BASE), .depth_log2(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (dat_i),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .io_in      (io),
        .sample_irq (irq)
    );

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, output logic acked);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = addr;
        @(posedge clk);
        #1;
        acked = ack;
        data  = dat_o;
        cyc = 1'b0; stb = 1'b0;
        $display("wb rd %h -> %h ack=%0b", addr, data, acked);
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] bsel,
                            output logic acked, output logic [15:0] ts_ack);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = bsel; adr = addr; dat_i = data;
        @(posedge clk);
        #1;
        acked  = ack;
        ts_ack = tb_ts;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("wb wr %h <- %h sel=%h ack=%0b", addr, data, bsel, acked);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic a;
        rst = 1'b1;
        idle(3);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", ack); end
        n_cmp++; if (dat_o !== 32'd0) begin n_bad++; $display("FAIL reset_dat: got %h want 0", dat_o); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        rst = 1'b0;
        wb_read(A_CTRL, d, a);
        n_cmp++; if (a !== 1'b1 || d !== 32'd0) begin n_bad++; $display("FAIL reset_ctrl: got %h ack %b want 0 ack 1", d, a); end
        wb_read(A_DIV, d, a);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_div: got %h want 0", d); end
        wb_read(A_STATUS, d, a);
        n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL reset_status: got %h want 100", d); end
        wb_read(A_DATA, d, a);
        n_cmp++; if (a !== 1'b1 || d !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h ack %b want 0 ack 1", d, a); end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        logic [31:0] exp;
        logic a;
        logic [15:0] t, t_w;
        io = '0;
        io[7:0] = 8'hA5;
        idle(3);
        wb_write(A_DIV, 32'd10, 4'hF, a, t);
        wb_write(A_CTRL, 32'h1, 4'hF, a, t_w);
        // Enabled at edge W; captures land on edges W+10, W+20, ...
        for (int k = 1; k <= 6; k++) sb_q.push_back({16'(t_w + 16'(10 * k - 1)), 8'hA5});
        for (int i = 0; i < 200 && tb_ts != 16'(t_w + 16'd64); i++) idle(1);
        wb_write(A_CTRL, 32'h0, 4'hF, a, t);
        wb_read(A_STATUS, d, a);
        n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL periodic_count: got %h want 6", d); end
        for (int i = 0; i < 6; i++) begin
            exp = {8'd0, sb_q.pop_front()};
            wb_read(A_DATA, d, a);
            n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL periodic_entry%0d: got %h want %h", i, d, exp); end
        end
        wb_read(A_DATA, d, a);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL periodic_empty_read: got %h want 0", d); end
    endtask

    task automatic test_on_change();
        logic [31:0] d;
        logic [31:0] exp;
        logic a;
        logic [15:0] t, tt;
        wb_write(A_CTRL, 32'h0803, 4'hF, a, t);
        idle(3);
        for (int n = 0; n < 3; n++) begin
            io[8] = ~io[8];
            tt = tb_ts;
            sb_q.push_back({16'(tt + 16'd2), io[15:8]});
            if (n == 0) begin
                idle(1);
                wb_read(A_STATUS, d, a);
                n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL onchg_before_push: got %h want 100", d); end
                wb_read(A_STATUS, d, a);
                n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL onchg_after_push: got %h want 1", d); end
            end else begin
                idle(4);
            end
        end
        wb_write(A_CTRL, 32'h0800, 4'hF, a, t);
        wb_read(A_STATUS, d, a);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL onchg_count: got %h want 3", d); end
        for (int i = 0; i < 3; i++) begin
            exp = {8'd0, sb_q.pop_front()};
            wb_read(A_DATA, d, a);
            n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL onchg_entry%0d: got %h want %h", i, d, exp); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic a;
        logic [15:0] t;
        wb_write(A_DIV, 32'd1, 4'hF, a, t);
        wb_write(A_CTRL, 32'h1, 4'hF, a, t);
        idle(20);
        wb_write(A_CTRL, 32'h0, 4'hF, a, t);
        wb_read(A_STATUS, d, a);
        n_cmp++; if (d !== 32'h610) begin n_bad++; $display("FAIL ovf_full: got %h want 610", d); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ovf_irq_off: got %b want 0", irq); end
        wb_write(A_STATUS, 32'h400, 4'hF, a, t);
        wb_read(A_STATUS, d, a);
        n_cmp++; if (d !== 32'h210) begin n_bad++; $display("FAIL ovf_clear: got %h want 210", d); end
        wb_write(A_CTRL, 32'h4, 4'hF, a, t);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_nonempty: got %b want 1", irq); end
        wb_write(A_CTRL, 32'h80000004, 4'hF, a, t);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_after_flush: got %b want 0", irq); end
        wb_read(A_STATUS, d, a);
        n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL flush_status: got %h want 100", d); end
        wb_read(A_CTRL, d, a);
        n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL flush_bit_readback: got %h want 4", d); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        logic [31:0] exp;
        logic a;
        logic [15:0] t, tt;
        io = '0;
        idle(3);
        wb_write(A_CTRL, 32'h0803, 4'hF, a, t);
        for (int n = 0; n < 16; n++) begin
            io[8] = ~io[8];
            tt = tb_ts;
            sb_q.push_back({16'(tt + 16'd2), io[15:8]});
            idle(3);
        end
        wb_read(A_STATUS, d, a);
        n_cmp++; if (d !== 32'h210) begin n_bad++; $display("FAIL simul_filled: got %h want 210", d); end
        // Pin edge timed so its capture lands on the same edge as the DATA pop.
        io[8] = ~io[8];
        tt = tb_ts;
        sb_q.push_back({16'(tt + 16'd2), io[15:8]});
        idle(2);
        exp = {8'd0, sb_q.pop_front()};
        wb_read(A_DATA, d, a);
        n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL simul_pop: got %h want %h", d, exp); end
        wb_read(A_STATUS, d, a);
        n_cmp++; if (d !== 32'h210) begin n_bad++; $display("FAIL simul_status: got %h want 210", d); end
        wb_write(A_CTRL, 32'h0800, 4'hF, a, t);
        for (int i = 0; i < 16; i++) begin
            exp = {8'd0, sb_q.pop_front()};
            wb_read(A_DATA, d, a);
            n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL simul_entry%0d: got %h want %h", i, d, exp); end
        end
        wb_read(A_STATUS, d, a);
        n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL simul_drained: got %h want 100", d); end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic a;
        logic [15:0] t;
        int acks;
        wb_read(BASE + 32'h40, d, a);
        n_cmp++; if (a !== 1'b1 || d !== 32'd0) begin n_bad++; $display("FAIL dec_hole: got %h ack %b want 0 ack 1", d, a); end
        wb_write(A_CTRL, 32'h106, 4'hF, a, t);
        wb_write(A_CTRL, 32'h0, 4'h1, a, t);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL dec_partial_ack: got %b want 1", a); end
        wb_read(A_CTRL, d, a);
        n_cmp++; if (d !== 32'h106) begin n_bad++; $display("FAIL dec_partial_ignored: got %h want 106", d); end
        wb_write(A_CTRL, 32'h3F00, 4'hF, a, t);
        wb_read(A_CTRL, d, a);
        n_cmp++; if (d !== 32'h1E00) begin n_bad++; $display("FAIL dec_lsb_clamp: got %h want 1e00", d); end

        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = A_DIV;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            $display("wb held rd %h cycle %0d -> %h ack=%0b", adr, i, dat_o, ack);
            n_cmp++;
            if (ack !== ((i % 2) == 0) || dat_o !== (((i % 2) == 0) ? 32'd1 : 32'd0)) begin
                n_bad++;
                $display("FAIL dec_held%0d: got %h ack %b want %h ack %b", i, dat_o, ack,
                         (((i % 2) == 0) ? 32'd1 : 32'd0), ((i % 2) == 0));
            end
        end
        cyc = 1'b0; stb = 1'b0;
        idle(1);

        acks = 0;
        cyc = 1'b1; stb = 1'b1; adr = 32'h30000600;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        $display("wb rd 30000600 held 8 cycles acks=%0d", acks);
        n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL dec_outside: got %0d acks want 0", acks); end
        idle(1);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CTRL; rst = 1'b1;
        @(posedge clk);
        #1;
        $display("wb rd %h under reset ack=%0b", adr, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL dec_reset_ack: got %b want 0", ack); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("wb rd %h after reset -> %h ack=%0b", adr, dat_o, ack);
        n_cmp++; if (ack !== 1'b1 || dat_o !== 32'd0) begin n_bad++; $display("FAIL dec_after_reset: got %h ack %b want 0 ack 1", dat_o, ack); end
        cyc = 1'b0; stb = 1'b0;
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        dat_i = '0; adr = '0; io = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_periodic();
        test_on_change();
        test_overflow();
        test_simultaneous();
        test_decode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_sample_fifo.md
# io_sample_fifo

Wishbone-mapped pad sampler on the user-side IO bus, alongside the project mux. Captures a selectable 8-bit slice of `io_in` into a 16-deep FIFO, either periodically or on change, tagging each entry with a 16-bit timestamp. Firmware drains the FIFO over Wishbone to observe the active project's pins without a logic analyzer.

## Interface
**Parameters**
- `address_base`, 32'h30000500: base of the 0x100-byte register window.
- `depth_log2`, 4: FIFO depth is 2^depth_log2 entries.

**Ports**
- `wb_clk_i`, in, 1: sole clock.
- `wb_rst_i`, in, 1: reset, synchronous, active-high.
- `wbs_stb_i`, in, 1: strobe.
- `wbs_cyc_i`, in, 1: cycle.
- `wbs_we_i`, in, 1: write enable.
- `wbs_sel_i`, in, 4: byte selects. Writes are honoured only when all four are set.
- `wbs_dat_i`, in, 32: write data.
- `wbs_adr_i`, in, 32: address.
- `wbs_ack_o`, out, 1: ack (registered).
- `wbs_dat_o`, out, 32: read data (registered).
- `io_in`, in, 38: pad inputs, asynchronous to the clock.
- `sample_irq`, out, 1: high when the FIFO is non-empty and CTRL.irq_en is set.

## Operation
**Register map**
- CTRL @+0x00, RW
  - bit0 `en`; bit1 `mode` (0 periodic, 1 on-change); bit2 `irq_en`; bits[13:8] `lsb`.
  - Writing bit31=1 flushes the FIFO. Bit31 reads back as 0.
  - Values of `lsb` above 30 are clamped to 30.
- DIV @+0x04, RW, bits[15:0]: sample period in clocks. 0 behaves as 1.
- STATUS @+0x08
  - Read: [4:0] count; bit8 empty; bit9 full; bit10 overflow (sticky).
  - Writing bit10=1 clears overflow.
- DATA @+0x0C, RO
  - Read returns {8'b0, ts[15:0], sample[7:0]} of the head entry and pops it.
  - A read while empty returns 0 and does not pop.

**Other addresses**
- Any other address inside the window: acked, reads 0, writes ignored.
- Addresses outside the window: never acked.

**Capture path**
- `io_in` passes through a 2-flop synchronizer.
- The slice is `sync[lsb+7:lsb]`.
- A free-running 16-bit `ts` counter increments every clock and wraps at 0xFFFF→0. It runs regardless of `en`.
- Periodic mode: a 16-bit `div_cnt` counts while `en`=1. When `div_cnt` reaches DIV-1, push the slice and reload `div_cnt` to 0.
- On-change mode: push when the slice differs from `last`, the register holding the last pushed value.
- Every push updates `last`.
- Setting `en` 0→1 loads `last` with the current slice and clears `div_cnt`. No push occurs on that cycle.

**FIFO behaviour**
- Push while full without a simultaneous pop: entry dropped, overflow set.
- Push and pop in the same cycle while full: both occur; overflow unchanged.
- Push and pop in the same cycle while empty: the push occurs; the read returns 0.
- Flush in the same cycle as a push: flush wins and the FIFO ends empty.
- Flush does not clear overflow.
- Pointers wrap modulo the depth.

**Reset values**
- CTRL 0; DIV 0; FIFO empty; overflow 0; `ts` 0; `last` 0.
- `wbs_ack_o` 0; `wbs_dat_o` 0; `sample_irq` 0.
- Reset mid-transaction drops the ack and any pending pop.

## Timing
- Wishbone transaction:
  - Given `cyc&stb`, with the address in the window and `wbs_ack_o` low: ack=1 and dat_o valid on the next clock.
  - The clock after that: ack=0 and dat_o=0.
  - An access held high therefore produces an ack every other cycle.
- Register updates and the DATA pop take effect on the same edge that raises ack.
- On-change latency: a pin edge at cycle N appears in the synchronizer at N+2, is pushed at N+3, and is visible in STATUS.count at N+3.
- Periodic mode: with DIV=D, consecutive entries differ in `ts` by exactly D (mod 2^16).
- `sample_irq` is registered and updates one clock after count changes.

## Structure
- Shared package holds the register offset constants (`REG_CTRL`, `REG_DIV`, `REG_STATUS`, `REG_DATA`), the CTRL bit positions, and the 24-bit entry layout.
- One sub-module, `sync_fifo` (parameterised width and depth; push, pop, flush, full, empty, count), instantiated with width 24.
- The top level contains the Wishbone decode, the synchronizer, the divider and the change detect.

## Test plan
- Reset, then read all registers → CTRL=0, DIV=0, STATUS=0x100, DATA=0; `sample_irq`=0.
- Periodic: DIV=10, CTRL=0x001 with `lsb`=0, io_in[7:0]=0xA5 → DATA entries read 0xA5 with `ts` deltas of exactly 10.
- On-change: CTRL=0x0803 (`lsb`=8), toggle io_in[8] three times → exactly 3 entries; the first is pushed 3 clocks after the first toggle.
- Overflow: DIV=1, run 20 clocks without reads → count=16, full=1, overflow=1. Write STATUS 0x400 → overflow=0. Write CTRL bit31 → STATUS=0x100.
- Simultaneous: while full, a DATA read coincides with a push → count stays 16 and overflow stays 0.
- Wishbone decode: a read of +0x40 is acked with 0; a write with `sel`=0x1 to CTRL is acked and leaves CTRL unchanged; an access to 0x30000600 is never acked; a reset asserted mid-transaction → ack=0 next clock.
